// File: rtl/bimodal_predictor_if.sv
// Fetch/resolution bundle for bimodal_predictor: the request and result inputs
// plus the registered prediction returned to fetch.
interface bimodal_predictor_if #(
    parameter int PC_BITS    = 32,
    parameter int INDEX_BITS = 6,
    parameter int CTR_BITS   = 2
);
    logic                  request;
    logic [PC_BITS-1:0]    req_pc;
    logic                  result;
    logic [PC_BITS-1:0]    res_pc;
    logic                  taken;
    logic [INDEX_BITS-1:0] res_hist;
    logic                  prediction;
    logic                  pred_valid;
    logic [CTR_BITS-1:0]   pred_ctr;
    logic [INDEX_BITS-1:0] pred_hist;

    modport master (
        output request, req_pc, result, res_pc, taken, res_hist,
        input  prediction, pred_valid, pred_ctr, pred_hist
    );

    modport slave (
        input  request, req_pc, result, res_pc, taken, res_hist,
        output prediction, pred_valid, pred_ctr, pred_hist
    );
endinterface

// File: rtl/bimodal_predictor.sv
// Table of 2^INDEX_BITS saturating counters with one registered prediction and one
// training update per cycle. Define GSHARE_EN to hash the index with global history.
module bimodal_predictor #(
    parameter int                  PC_BITS    = 32,
    parameter int                  INDEX_BITS = 6,
    parameter int                  CTR_BITS   = 2,
    parameter logic [CTR_BITS-1:0] CTR_INIT   = {CTR_BITS{1'b1}}
) (
    input logic          clk,
    input logic          rst_n,
    bimodal_predictor_if.slave bus
);
    localparam int                  ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_MIN = {CTR_BITS{1'b0}};
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1'b1);

    logic [CTR_BITS-1:0]   table_r [ENTRIES];
    logic [INDEX_BITS-1:0] hist_s;
    logic [INDEX_BITS-1:0] rd_idx_s;
    logic [INDEX_BITS-1:0] wr_idx_s;
    logic [CTR_BITS-1:0]   rd_ctr_s;
    logic [CTR_BITS-1:0]   next_ctr_s;
    logic                  prediction_r;
    logic                  pred_valid_r;
    logic [CTR_BITS-1:0]   pred_ctr_r;
    logic [INDEX_BITS-1:0] pred_hist_r;
    logic                  unused_s;

    // Saturating step: move toward the outcome, never wrap at either end.
    function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] ctr,
                                                     input logic up);
        logic [CTR_BITS-1:0] nxt;
        nxt = ctr;
        if (up) begin
            if (ctr != CTR_MAX) nxt = ctr + CTR_ONE;
            else                nxt = ctr;
        end else begin
            if (ctr != CTR_MIN) nxt = ctr - CTR_ONE;
            else                nxt = ctr;
        end
        return nxt;
    endfunction

`ifdef GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_r;
    logic [INDEX_BITS:0]   ghr_shift_s;

    // Dropping the top bit of {ghr, taken} gives the shift for any INDEX_BITS >= 1.
    assign ghr_shift_s = {ghr_r, bus.taken};
    assign hist_s      = ghr_r;
    assign rd_idx_s    = bus.req_pc[INDEX_BITS+1:2] ^ ghr_r;
    assign wr_idx_s    = bus.res_pc[INDEX_BITS+1:2] ^ bus.res_hist;
    assign unused_s    = ^{bus.req_pc[PC_BITS-1:INDEX_BITS+2], bus.req_pc[1:0],
                           bus.res_pc[PC_BITS-1:INDEX_BITS+2], bus.res_pc[1:0]};

    // Global history shifts in each resolved outcome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_r <= {INDEX_BITS{1'b0}};
        end else if (bus.result) begin
            ghr_r <= ghr_shift_s[INDEX_BITS-1:0];
        end else begin
            ghr_r <= ghr_r;
        end
    end
`else
    assign hist_s   = {INDEX_BITS{1'b0}};
    assign rd_idx_s = bus.req_pc[INDEX_BITS+1:2];
    assign wr_idx_s = bus.res_pc[INDEX_BITS+1:2];
    assign unused_s = ^{bus.req_pc[PC_BITS-1:INDEX_BITS+2], bus.req_pc[1:0],
                       bus.res_pc[PC_BITS-1:INDEX_BITS+2], bus.res_pc[1:0],
                       bus.res_hist};
`endif

    // Read port and next value of the entry being trained.
    always_comb begin
        rd_ctr_s   = table_r[rd_idx_s];
        next_ctr_s = sat_step(table_r[wr_idx_s], bus.taken);
    end

    // Counter table; a read on the same index as an update sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= CTR_INIT;
            end
        end else if (bus.result) begin
            table_r[wr_idx_s] <= next_ctr_s;
        end else begin
            table_r[wr_idx_s] <= table_r[wr_idx_s];
        end
    end

    // Prediction outputs load on a request and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_r <= 1'b0;
            prediction_r <= 1'b0;
            pred_ctr_r   <= {CTR_BITS{1'b0}};
            pred_hist_r  <= {INDEX_BITS{1'b0}};
        end else begin
            pred_valid_r <= bus.request;
            if (bus.request) begin
                prediction_r <= rd_ctr_s[CTR_BITS-1];
                pred_ctr_r   <= rd_ctr_s;
                pred_hist_r  <= hist_s;
            end else begin
                prediction_r <= prediction_r;
                pred_ctr_r   <= pred_ctr_r;
                pred_hist_r  <= pred_hist_r;
            end
        end
    end

    assign bus.prediction = prediction_r;
    assign bus.pred_valid = pred_valid_r;
    assign bus.pred_ctr   = pred_ctr_r;
    assign bus.pred_hist  = pred_hist_r;
endmodule

// File: tb/tb_bimodal_predictor.sv
// Self-checking bench for bimodal_predictor: a directed vector table, an async
// reset sequence, a full-table sweep and a random phase against a reference model.
`timescale 1ns/1ps
module tb_bimodal_predictor;
    localparam int PC_BITS    = 32;
    localparam int INDEX_BITS = 6;
    localparam int CTR_BITS   = 2;
    localparam int ENTRIES    = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bimodal_predictor_if #(.PC_BITS(PC_BITS), .INDEX_BITS(INDEX_BITS), .CTR_BITS(CTR_BITS)) bus ();

    bimodal_predictor #(.PC_BITS(PC_BITS), .INDEX_BITS(INDEX_BITS), .CTR_BITS(CTR_BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        request;
        logic [31:0] req_pc;
        logic        result;
        logic [31:0] res_pc;
        logic        taken;
        logic [5:0]  res_hist;
        logic        exp_pred;
        logic [1:0]  exp_ctr;
        logic [5:0]  exp_hist;
    } vec_t;

    typedef struct {
        logic       pred;
        logic [1:0] ctr;
        logic [5:0] hist;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   vectors     = 0;
    int   miscompares = 0;
    int   model_ctr [ENTRIES];
    logic [5:0] model_ghr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) model_ctr[i] = 3;
        model_ghr = 6'd0;
    endfunction

    function automatic exp_t model_predict(input logic [31:0] pc);
        exp_t m;
        logic [5:0] h;
        logic [5:0] idx;
`ifdef GSHARE_EN
        h = model_ghr;
`else
        h = 6'd0;
`endif
        idx    = pc[7:2] ^ h;
        m.ctr  = 2'(model_ctr[idx]);
        m.pred = (model_ctr[idx] >= 2);
        m.hist = h;
        return m;
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic tk, input logic [5:0] rh);
        logic [5:0] idx;
`ifdef GSHARE_EN
        idx = pc[7:2] ^ rh;
`else
        idx = pc[7:2];
`endif
        if (tk) model_ctr[idx] = (model_ctr[idx] == 3) ? 3 : model_ctr[idx] + 1;
        else    model_ctr[idx] = (model_ctr[idx] == 0) ? 0 : model_ctr[idx] - 1;
        model_ghr = {model_ghr[4:0], tk};
    endfunction

    function automatic vec_t mk(input logic rq, input logic [31:0] rpc, input logic rs,
                                input logic [31:0] upc, input logic tk, input logic [5:0] rh,
                                input logic ep, input logic [1:0] ec, input logic [5:0] eh);
        vec_t v;
        v.request = rq; v.req_pc = rpc; v.result = rs; v.res_pc = upc; v.taken = tk;
        v.res_hist = rh; v.exp_pred = ep; v.exp_ctr = ec; v.exp_hist = eh;
        return v;
    endfunction

    task automatic check_out(input logic req);
        exp_t e;
        chk("pred_valid", {31'd0, bus.pred_valid}, {31'd0, req});
        if (req) begin
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("prediction", {31'd0, bus.prediction}, {31'd0, e.pred});
                chk("pred_ctr", {30'd0, bus.pred_ctr}, {30'd0, e.ctr});
                chk("pred_hist", {26'd0, bus.pred_hist}, {26'd0, e.hist});
                last_exp = e;
            end
        end else begin
            chk("hold_prediction", {31'd0, bus.prediction}, {31'd0, last_exp.pred});
            chk("hold_pred_ctr", {30'd0, bus.pred_ctr}, {30'd0, last_exp.ctr});
        end
    endtask

    // One cycle: drive at negedge, expect pushed before the edge, checked 1ns after it.
    task automatic drive(input vec_t v, input logic use_tab);
        exp_t e;
        @(negedge clk);
        bus.request  = v.request;
        bus.req_pc   = v.req_pc;
        bus.result   = v.result;
        bus.res_pc   = v.res_pc;
        bus.taken    = v.taken;
        bus.res_hist = v.res_hist;
        if (v.request) begin
            if (use_tab) begin
                e.pred = v.exp_pred; e.ctr = v.exp_ctr; e.hist = v.exp_hist;
            end else begin
                e = model_predict(v.req_pc);
            end
            sb_q.push_back(e);
        end
        if (v.result) model_update(v.res_pc, v.taken, v.res_hist);
        @(posedge clk);
        #1;
        check_out(v.request);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "time limit");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;

        bus.request = 1'b0; bus.req_pc = 32'd0; bus.result = 1'b0;
        bus.res_pc = 32'd0; bus.taken = 1'b0; bus.res_hist = 6'd0;
        model_reset();
        last_exp = '{1'b0, 2'd0, 6'd0};

        #2;
        chk("rst_prediction", {31'd0, bus.prediction}, 32'd0);
        chk("rst_pred_valid", {31'd0, bus.pred_valid}, 32'd0);
        chk("rst_pred_ctr", {30'd0, bus.pred_ctr}, 32'd0);
        chk("rst_pred_hist", {26'd0, bus.pred_hist}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef GSHARE_EN
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 32'h00, 1'b1, 6'd0, 1'b0, 2'd0, 6'd0));
        vecs.push_back(mk(1'b1, 32'h00, 1'b0, 32'h0, 1'b0, 6'd0, 1'b1, 2'd3, 6'd1));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 32'h00, 1'b0, 6'd1, 1'b0, 2'd0, 6'd0));
        vecs.push_back(mk(1'b1, 32'h08, 1'b0, 32'h0, 1'b0, 6'd0, 1'b1, 2'd3, 6'd2));
        vecs.push_back(mk(1'b1, 32'h0C, 1'b0, 32'h0, 1'b0, 6'd0, 1'b1, 2'd2, 6'd2));
`else
        vecs.push_back(mk(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 6'd0, 1'b1, 2'd3, 6'd0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 6'h15, 1'b0, 2'd0, 6'd0));
        vecs.push_back(mk(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 2'd0, 6'd0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 6'd0, 1'b0, 2'd0, 6'd0));
        vecs.push_back(mk(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 2'd0, 6'd0));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 6'd0, 1'b0, 2'd0, 6'd0));
        vecs.push_back(mk(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 6'd0, 1'b1, 2'd2, 6'd0));
        vecs.push_back(mk(1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 6'd0, 1'b1, 2'd3, 6'd0));
        vecs.push_back(mk(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 6'd0, 1'b1, 2'd2, 6'd0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b0, 32'h0, 1'b1, 32'h04, 1'b0, 6'h2A, 1'b0, 2'd0, 6'd0));
        vecs.push_back(mk(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 2'd0, 6'd0));
        vecs.push_back(mk(1'b1, 32'h08, 1'b0, 32'h0, 1'b0, 6'd0, 1'b1, 2'd3, 6'd0));
        vecs.push_back(mk(1'b1, 32'hFFFF_0107, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 2'd0, 6'd0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 2'd0, 6'd0));
        vecs.push_back(mk(1'b1, 32'h08, 1'b1, 32'h0C, 1'b1, 6'd0, 1'b1, 2'd3, 6'd0));
`endif
        for (int i = 0; i < vecs.size(); i++) drive(vecs[i], 1'b1);

        // Async reset with a request and an update in flight: both must be dropped.
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, bus.pred_valid}, 32'd1);
        bus.request = 1'b1; bus.req_pc = 32'h40;
        bus.result = 1'b1; bus.res_pc = 32'h08; bus.taken = 1'b0; bus.res_hist = 6'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_prediction", {31'd0, bus.prediction}, 32'd0);
        chk("async_pred_valid", {31'd0, bus.pred_valid}, 32'd0);
        chk("async_pred_ctr", {30'd0, bus.pred_ctr}, 32'd0);
        chk("async_pred_hist", {26'd0, bus.pred_hist}, 32'd0);
        @(negedge clk);
        chk("rst_hold_valid", {31'd0, bus.pred_valid}, 32'd0);
        bus.request = 1'b0; bus.result = 1'b0;
        model_reset();
        sb_q.delete();
        last_exp = '{1'b0, 2'd0, 6'd0};
        rst_n = 1'b1;

        for (int i = 0; i < ENTRIES; i++) begin
            v = mk(1'b1, 32'(i) << 2, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 2'd0, 6'd0);
            drive(v, 1'b0);
        end

        for (int n = 0; n < 400; n++) begin
            v.request  = 1'($urandom_range(0, 1));
            v.req_pc   = $urandom;
            v.req_pc[7:2] = 6'($urandom_range(0, 7));
            v.result   = 1'($urandom_range(0, 1));
            v.res_pc   = $urandom;
            v.res_pc[7:2] = 6'($urandom_range(0, 7));
            v.taken    = 1'($urandom_range(0, 1));
            v.res_hist = 6'($urandom_range(0, 7));
            drive(v, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
